// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared definitions for the instruction-fetch stage.
//                Contains the reset PC default, the RV32I major opcodes seen
//                by the downstream decoder, the fetch FSM state encoding, the
//                FIFO entry layout and a PC alignment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_0000;

    // Major opcodes consumed by the main decoder
    localparam logic [6:0] c_OP_R  = 7'b0110011;
    localparam logic [6:0] c_OP_LW = 7'b0000011;
    localparam logic [6:0] c_OP_I  = 7'b0010011;
    localparam logic [6:0] c_OP_S  = 7'b0100011;
    localparam logic [6:0] c_OP_B  = 7'b1100011;

    // Fetch FSM encoding
    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_e;

    // One buffered instruction together with the PC it was fetched from
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Branch targets may carry junk in the low bits; fetch is word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small synchronous FIFO holding {pc, instr} entries between
//                the instruction-memory response path and the decoder.
//                Ports:
//                  clk, rst        - clock, asynchronous active-high reset
//                  push / wr_data  - write one entry
//                  pop             - retire the head entry
//                  clear           - drop all entries (redirect)
//                  rd_data         - head entry
//                  count           - number of valid entries
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  fetch_entry_t  wr_data,
    output fetch_entry_t  rd_data,
    output logic [CW-1:0] count
);

    localparam int            c_AW    = $clog2(DEPTH);
    localparam logic [CW-1:0] c_FULL  = CW'(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == c_FULL);
    assign w_do_pop  = pop  & (r_count != '0);
    // Writing while full is only safe when the head leaves in the same cycle
    assign w_do_push = push & (~w_full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            assert (!(push && w_full && !w_do_pop));
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Holds the PC, issues in-order
//                requests over a valid/ready channel, buffers responses and
//                hands one instruction per handshake to the decoder with the
//                op/funct3/funct7b5 fields pre-sliced. A taken branch
//                (redirect) reloads the PC and flushes stale fetches.
//                Ports:
//                  clk, rst                         - clock, async reset
//                  imem_req_valid/addr/ready        - fetch request channel
//                  imem_rsp_valid/data              - in-order responses
//                  instr_valid/ready, instr, instr_pc,
//                  op, funct3, funct7b5             - decoder interface
//                  redirect, redirect_target        - taken branch/jump
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = c_RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    input  logic        redirect,
    input  logic [31:0] redirect_target
);

    localparam int              c_CW      = $clog2(BUF_DEPTH) + 1;
    localparam logic [c_CW:0]   c_DEPTH_W = (c_CW + 1)'(BUF_DEPTH);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_ret_pc;
    logic [31:0]     w_target;
    logic [c_CW-1:0] r_inflight;
    logic [c_CW-1:0] r_drop_cnt;
    logic [c_CW-1:0] w_drop_nxt;
    logic [c_CW-1:0] w_redirect_drop;
    logic [c_CW-1:0] w_fifo_count;
    logic [c_CW:0]   w_credit_sum;
    logic            w_credit_ok;
    logic            w_req_fire;
    logic            w_push;
    logic            w_pop;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    // ------------------------------------------------------------------
    // Request side: a request is only issued when a FIFO slot is reserved
    // for its response, so the buffer can never overflow.
    // ------------------------------------------------------------------
    assign w_credit_sum   = {1'b0, r_inflight} + {1'b0, w_fifo_count};
    assign w_credit_ok    = (w_credit_sum < c_DEPTH_W);
    assign imem_req_valid = (r_state == S_RUN) & w_credit_ok & ~redirect;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    assign w_target       = align_pc(redirect_target);

    // ------------------------------------------------------------------
    // Response side: only responses belonging to the current stream are
    // buffered; the response landing on a redirect cycle is stale.
    // ------------------------------------------------------------------
    assign w_push            = imem_rsp_valid & (r_state == S_RUN) & ~redirect;
    assign w_push_entry.pc    = r_ret_pc;
    assign w_push_entry.instr = imem_rsp_data;

    assign w_pop = instr_valid & instr_ready;

    // Responses still owed by memory once this redirect cycle completes
    assign w_redirect_drop = r_inflight + c_CW'(w_req_fire) - c_CW'(imem_rsp_valid);

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .CW    (c_CW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .pop     (w_pop),
        .clear   (redirect),
        .wr_data (w_push_entry),
        .rd_data (w_head),
        .count   (w_fifo_count)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_BOOT;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_drop_cnt <= w_drop_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and drop counter
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop_cnt;
        if (redirect) begin
            w_drop_nxt  = w_redirect_drop;
            w_state_nxt = (w_redirect_drop != '0) ? S_FLUSH : S_RUN;
        end else begin
            case (r_state)
                S_BOOT: begin
                    w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    w_state_nxt = S_RUN;
                end
                S_FLUSH: begin
                    if (imem_rsp_valid) begin
                        w_drop_nxt = r_drop_cnt - 1'b1;
                        if (w_drop_nxt == '0) begin
                            w_state_nxt = S_RUN;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_BOOT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // PC tracking and outstanding-request counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_ret_pc   <= RESET_PC;
            r_inflight <= '0;
        end else begin
            r_inflight <= r_inflight + c_CW'(w_req_fire) - c_CW'(imem_rsp_valid);
            if (redirect) begin
                r_fetch_pc <= w_target;
                r_ret_pc   <= w_target;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                // Responses return in order, so the PC of each buffered word
                // is simply the next sequential address of the stream.
                if (w_push) begin
                    r_ret_pc <= r_ret_pc + 32'd4;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Decoder interface
    // ------------------------------------------------------------------
    assign instr_valid = (w_fifo_count != '0);
    assign instr       = w_head.instr;
    assign instr_pc    = w_head.pc;
    assign op          = w_head.instr[6:0];
    assign funct3      = w_head.instr[14:12];
    assign funct7b5    = w_head.instr[30];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit. A behavioural
//                instruction memory answers requests in order after a
//                configurable latency; every fired request queues its
//                expected {pc, word} and each decoder handshake is checked
//                against the head of that queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        redirect;
    logic [31:0] redirect_target;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .op              (op),
        .funct3          (funct3),
        .funct7b5        (funct7b5),
        .redirect        (redirect),
        .redirect_target (redirect_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    mreq_t mem_q[$];
    exp_t  exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 1;
    int exp_drop = 0;

    logic        s_fire, s_pop, s_req_valid, s_instr_valid;
    logic [31:0] s_addr, s_instr_pc;
    logic [6:0]  s_op;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        if (a == 32'h0) return 32'h0020_8033;
        return {~a[24:0], 7'h13};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, update the memory model and
    // scoreboard, then drive the next cycle's response just after the rise.
    task automatic tick();
        exp_t  e;
        mreq_t m;
        @(negedge clk);
        s_req_valid   = imem_req_valid;
        s_addr        = imem_req_addr;
        s_instr_valid = instr_valid;
        s_instr_pc    = instr_pc;
        s_op          = op;
        s_fire        = imem_req_valid && imem_req_ready && !rst;
        s_pop         = instr_valid && instr_ready && !rst;
        if (s_pop) begin
            if (exp_q.size() == 0) begin
                chk("sb_nonempty_at_pop", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("instr",    instr,           e.word);
                chk("instr_pc", instr_pc,        e.pc);
                chk("op",       32'(op),         32'(e.word[6:0]));
                chk("funct3",   32'(funct3),     32'(e.word[14:12]));
                chk("funct7b5", 32'(funct7b5),   32'(e.word[30]));
            end
        end
        if (redirect) begin
            exp_drop = int'(mem_q.size()) + int'(s_fire) - int'(imem_rsp_valid);
            exp_q.delete();
        end
        if (imem_rsp_valid && mem_q.size() > 0) begin
            m = mem_q.pop_front();
        end
        if (s_fire) begin
            m.addr = imem_req_addr;
            m.due  = cyc + lat;
            mem_q.push_back(m);
            e.pc   = imem_req_addr;
            e.word = word_of(imem_req_addr);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect       = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mem_q.delete();
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Stop fetching and let every outstanding word reach the decoder
    task automatic drain(input string tag);
        imem_req_ready = 1'b0;
        instr_ready    = 1'b1;
        for (int i = 0; i < 30 && (mem_q.size() > 0 || exp_q.size() > 0); i++) tick();
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    int          first_valid, nf, np, nxt_addr, pop_pc, fire_addr;
    logic        found;
    logic [31:0] fire_log[$];
    int          fire_cyc[$];

    initial begin
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = '0;
        instr_ready     = 1'b0;
        redirect        = 1'b0;
        redirect_target = '0;

        // ---------------- reset values ----------------
        tick();
        chk("rst_req_valid",   32'(s_req_valid),   32'd0);
        chk("rst_req_addr",    s_addr,             32'h0);
        chk("rst_instr_valid", 32'(s_instr_valid), 32'd0);
        chk("rst_instr_pc",    s_instr_pc,         32'h0);
        chk("rst_op",          32'(s_op),          32'd0);

        // ---------------- streaming fetch, 1-cycle memory ----------------
        do_reset();
        lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        tick();
        chk("t1_boot_no_req", 32'(s_req_valid), 32'd0);
        fire_log.delete(); fire_cyc.delete(); first_valid = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_fire) begin
                fire_log.push_back(s_addr);
                fire_cyc.push_back(cyc - 1);
            end
            if (s_instr_valid && first_valid < 0) begin
                first_valid = cyc - 1;
                chk("t1_first_op", 32'(s_op), 32'h33);
            end
        end
        chk("t1_enough_fires", 32'(fire_log.size() >= 3), 32'd1);
        if (fire_log.size() >= 3) begin
            chk("t1_addr0", fire_log[0], 32'h0);
            chk("t1_addr1", fire_log[1], 32'h4);
            chk("t1_addr2", fire_log[2], 32'h8);
            chk("t1_back_to_back", 32'(fire_cyc[1] - fire_cyc[0]), 32'd1);
            chk("t1_rsp_to_valid", 32'(first_valid - fire_cyc[0]), 32'd2);
        end
        drain("t1_drain");

        // ---------------- decoder stalled ----------------
        do_reset();
        lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b0;
        nf = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (s_fire) nf++;
        end
        chk("t2_fire_count",  32'(nf),            32'd2);
        chk("t2_req_dropped", 32'(s_req_valid),   32'd0);
        chk("t2_buffered",    32'(s_instr_valid), 32'd1);
        instr_ready = 1'b1;
        np = 0; nxt_addr = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i < 2 && s_pop) np++;
            if (s_fire && nxt_addr < 0) nxt_addr = int'(s_addr);
        end
        chk("t2_pops_back_to_back", 32'(np),       32'd2);
        chk("t2_resume_addr",       32'(nxt_addr), 32'h8);
        drain("t2_drain");

        // ---------------- memory backpressure ----------------
        do_reset();
        lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        tick();
        tick();
        chk("t3_fire0", 32'(s_fire), 32'd1);
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_hold_valid", 32'(s_req_valid), 32'd1);
            chk("t3_hold_addr",  s_addr,           32'h4);
        end
        imem_req_ready = 1'b1;
        tick();
        chk("t3_fire_valid", 32'(s_fire), 32'd1);
        chk("t3_fire_addr",  s_addr,      32'h4);
        tick();
        chk("t3_pc_advance", s_addr, 32'h8);
        drain("t3_drain");

        // ---------------- redirect with two fetches in flight ----------------
        do_reset();
        lat = 3; imem_req_ready = 1'b1; instr_ready = 1'b1;
        tick();
        tick();
        tick();
        redirect = 1'b1; redirect_target = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        chk("t4_redirect_no_req", 32'(s_req_valid),       32'd0);
        chk("t4_drop_cnt",        32'(dut.r_drop_cnt),    32'(exp_drop));
        fire_addr = -1; pop_pc = -1;
        for (int i = 0; i < 30 && pop_pc < 0; i++) begin
            tick();
            if (s_fire && fire_addr < 0) begin
                fire_addr = int'(s_addr);
                chk("t4_stale_done_first", 32'(mem_q.size()), 32'd1);
            end
            if (s_pop && pop_pc < 0) pop_pc = int'(s_instr_pc);
        end
        chk("t4_new_addr",     32'(fire_addr), 32'h100);
        chk("t4_first_pop_pc", 32'(pop_pc),    32'h100);
        drain("t4_drain");

        // ---------------- redirect with pop and response together ----------------
        do_reset();
        lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        tick();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (imem_rsp_valid && instr_valid) found = 1'b1;
        end
        chk("t5_setup_found", 32'(found), 32'd1);
        redirect = 1'b1; redirect_target = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        chk("t5_pop_completed", 32'(s_pop),            32'd1);
        chk("t5_drop_cnt",      32'(dut.r_drop_cnt),   32'(exp_drop));
        tick();
        chk("t5_fifo_empty",    32'(s_instr_valid),    32'd0);
        chk("t5_req_fire",      32'(s_fire),           32'd1);
        chk("t5_req_addr",      s_addr,                32'h200);
        drain("t5_drain");

        // ---------------- reset in the middle of a flush ----------------
        do_reset();
        lat = 3; imem_req_ready = 1'b1; instr_ready = 1'b1;
        tick();
        tick();
        tick();
        redirect = 1'b1; redirect_target = 32'h0000_0300;
        tick();
        redirect = 1'b0;
        tick();
        chk("t6_flushing", 32'(dut.r_drop_cnt != '0), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_async_req_valid",   32'(imem_req_valid),   32'd0);
        chk("t6_async_req_addr",    imem_req_addr,         32'h0);
        chk("t6_async_instr_valid", 32'(instr_valid),      32'd0);
        chk("t6_async_drop_cnt",    32'(dut.r_drop_cnt),   32'd0);
        mem_q.delete();
        exp_q.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_boot_no_req", 32'(s_req_valid), 32'd0);
        tick();
        chk("t6_fire",        32'(s_fire),      32'd1);
        chk("t6_fire_addr",   s_addr,           32'h0);
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
